// File: rtl/inst_fetch_buf_pkg.sv
// Shared constants for the instruction prefetch buffer.
//   RstEnable / ChipEnable / ChipDisable : control-level encodings
//   InstAddrBusW / InstBusW              : default address / instruction widths
//   cnt_width()                          : occupancy counter width for a depth
package inst_fetch_buf_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int InstAddrBusW = 32;
  localparam int InstBusW     = 32;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Bus bundle between the prefetch buffer, the instruction ROM and the decode side.
//   flush_i / flush_pc_i     : branch redirect and its target
//   rom_ce_o / rom_addr_o    : ROM read request
//   rom_data_i               : ROM word, one cycle after the request
//   out_valid_o / out_pc_o / out_inst_o / out_ready_i : head-of-queue handshake
//   count_o                  : queue occupancy
// Modport master is the buffer itself; slave is the surrounding pipeline/ROM.
interface inst_fetch_buf_if
  import inst_fetch_buf_pkg::*;
#(
  parameter int ADDR_W = InstAddrBusW,
  parameter int INST_W = InstBusW,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic              flush_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_data_i;
  logic              out_valid_o;
  logic [ADDR_W-1:0] out_pc_o;
  logic [INST_W-1:0] out_inst_o;
  logic              out_ready_i;
  logic [CNT_W-1:0]  count_o;

  modport master (
    input  flush_i, flush_pc_i, rom_data_i, out_ready_i,
    output rom_ce_o, rom_addr_o, out_valid_o, out_pc_o, out_inst_o, count_o
  );

  modport slave (
    output flush_i, flush_pc_i, rom_data_i, out_ready_i,
    input  rom_ce_o, rom_addr_o, out_valid_o, out_pc_o, out_inst_o, count_o
  );

endinterface

// File: rtl/inst_fetch_buf_fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular queue of {pc, inst} words.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : drop all entries (pointers and count to zero, storage kept)
//   push_i    : write wdata_i at the write pointer
//   pop_i     : retire the head entry
//   rdata_o   : head entry (storage at the read pointer)
//   count_o   : number of valid entries
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [ENTRY_W-1:0]         wdata_i,
  output logic [ENTRY_W-1:0]         rdata_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: autonomous instruction prefetch engine with a DEPTH-entry
// {pc, inst} queue between the instruction ROM and the IF/ID register.
//   clk, rst : clock, synchronous active-high reset (overrides flush)
//   bus      : inst_fetch_buf_if.master (redirect, ROM request/return,
//              head handshake, occupancy)
// Optional feature: define FETCH_BUF_BYPASS_EN to present a returning ROM word
// on the output in its return cycle when the queue is empty; such a word is
// not written into the queue if it is consumed in that same cycle.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBusW,
  parameter int                INST_W   = InstBusW,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  inst_fetch_buf_if.master    bus
);
  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int OCC_W   = CNT_W + 1;
  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;

  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fifo_count;
  logic               ret, pop, issue;
  logic               fifo_push, fifo_pop;
  logic [OCC_W-1:0]   occ;

  // A fetch issued last cycle returns now unless a redirect kills it.
  assign ret = pend_q & ~bus.flush_i;

`ifdef FETCH_BUF_BYPASS_EN
  logic byp;
  assign byp             = ret & (fifo_count == '0);
  assign bus.out_valid_o = ~bus.flush_i & ((fifo_count != '0) | byp);
  assign bus.out_pc_o    = byp ? pend_pc_q      : head[ENTRY_W-1 -: ADDR_W];
  assign bus.out_inst_o  = byp ? bus.rom_data_i : head[INST_W-1:0];
  assign pop             = bus.out_valid_o & bus.out_ready_i & ~bus.flush_i;
  // A bypassed word that is consumed immediately never enters the queue.
  assign fifo_push       = ret & ~(byp & pop);
  assign fifo_pop        = pop & (fifo_count != '0);
`else
  assign bus.out_valid_o = ~bus.flush_i & (fifo_count != '0);
  assign bus.out_pc_o    = head[ENTRY_W-1 -: ADDR_W];
  assign bus.out_inst_o  = head[INST_W-1:0];
  assign pop             = bus.out_valid_o & bus.out_ready_i & ~bus.flush_i;
  assign fifo_push       = ret;
  assign fifo_pop        = pop;
`endif

  // Reserve a slot for every in-flight word: occupancy after this cycle's pop,
  // counting the pending return, must leave room for one more.
  assign occ   = OCC_W'(fifo_count) + OCC_W'(pend_q) - OCC_W'(pop);
  assign issue = ~rst & ~bus.flush_i & (occ < OCC_W'(DEPTH));

  assign bus.rom_ce_o   = issue ? ChipEnable : ChipDisable;
  assign bus.rom_addr_o = fetch_pc_q;
  assign bus.count_o    = fifo_count;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    if (bus.flush_i) begin
      fetch_pc_d = bus.flush_pc_i;
    end else if (issue) begin
      pend_d     = 1'b1;
      pend_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      fetch_pc_q <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.flush_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({pend_pc_q, bus.rom_data_i}),
    .rdata_o (head),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: a DEPTH=4 instance driven from a vector
// table plus a DEPTH=2 instance driven with a toggling ready and checked
// against a running expected-PC counter. The ROM model returns its address.
module tb_inst_fetch_buf;

  logic clk = 1'b0;
  logic rst4, rst2;
  always #5 clk = ~clk;

  inst_fetch_buf_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) if4 ();
  inst_fetch_buf_if #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) if2 ();

  inst_fetch_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  inst_fetch_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(2), .RESET_PC(32'h0)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (if2)
  );

  // Synchronous ROM: word = address, one cycle after the enable.
  always @(posedge clk) begin
    if (if4.rom_ce_o) if4.rom_data_i <= if4.rom_addr_o;
    if (if2.rom_ce_o) if2.rom_data_i <= if2.rom_addr_o;
  end

  typedef struct {
    logic        rst;
    logic        ready;
    logic        flush;
    logic [31:0] fpc;
    logic        ce;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        chk;
  } vec_t;

  vec_t tv[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input int idx);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic fl,
                     input logic [31:0] fpc, input logic ce,
                     input logic [31:0] addr, input logic vld,
                     input logic [31:0] pc, input logic [31:0] cnt,
                     input logic chk);
    vec_t v;
    v.rst = r; v.ready = rdy; v.flush = fl; v.fpc = fpc; v.ce = ce;
    v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt; v.chk = chk;
    tv.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_next;
    int pops;

    rst4 = 1'b1;
    rst2 = 1'b1;
    if4.flush_i = 1'b0; if4.flush_pc_i = '0; if4.out_ready_i = 1'b1; if4.rom_data_i = '0;
    if2.flush_i = 1'b0; if2.flush_pc_i = '0; if2.out_ready_i = 1'b0; if2.rom_data_i = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ce",    32'(if4.rom_ce_o),    32'h0, 0);
    check("rst_valid", 32'(if4.out_valid_o), 32'h0, 0);
    check("rst_pc",    if4.out_pc_o,         32'h0, 0);
    check("rst_inst",  if4.out_inst_o,       32'h0, 0);
    check("rst_count", 32'(if4.count_o),     32'h0, 0);
    check("rst_addr",  if4.rom_addr_o,       32'h0, 0);

`ifdef FETCH_BUF_BYPASS_EN
    // Bypass: word visible in its return cycle, queue never fills under ready=1.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rst4 = 1'b0;
      if4.out_ready_i = 1'b1;
      #1;
      check("byp_ce",    32'(if4.rom_ce_o),    32'h1, k);
      check("byp_addr",  if4.rom_addr_o,       32'(4 * (k - 1)), k);
      check("byp_valid", 32'(if4.out_valid_o), (k >= 2) ? 32'h1 : 32'h0, k);
      check("byp_count", 32'(if4.count_o),     32'h0, k);
      if (k >= 2) begin
        check("byp_pc",   if4.out_pc_o,   32'(4 * (k - 2)), k);
        check("byp_inst", if4.out_inst_o, 32'(4 * (k - 2)), k);
      end
    end
`else
    // Streaming from reset with ready=1.
    add(0,1,0,0,      1,32'h00,0,32'h00,0,1);
    add(0,1,0,0,      1,32'h04,0,32'h00,0,1);
    add(0,1,0,0,      1,32'h08,1,32'h00,1,1);
    add(0,1,0,0,      1,32'h0C,1,32'h04,1,1);
    add(0,1,0,0,      1,32'h10,1,32'h08,1,1);
    add(0,1,0,0,      1,32'h14,1,32'h0C,1,1);
    // Reset, then stall: exactly four issues fill the queue.
    add(1,0,0,0,      0,32'h00,0,32'h00,0,0);
    add(0,0,0,0,      1,32'h00,0,32'h00,0,1);
    add(0,0,0,0,      1,32'h04,0,32'h00,0,1);
    add(0,0,0,0,      1,32'h08,1,32'h00,1,1);
    add(0,0,0,0,      1,32'h0C,1,32'h00,2,1);
    add(0,0,0,0,      0,32'h10,1,32'h00,3,1);
    add(0,0,0,0,      0,32'h10,1,32'h00,4,1);
    add(0,0,0,0,      0,32'h10,1,32'h00,4,1);
    // Release: pops 0,4,8,C back to back, issue resumes immediately.
    add(0,1,0,0,      1,32'h10,1,32'h00,4,1);
    add(0,1,0,0,      1,32'h14,1,32'h04,3,1);
    add(0,1,0,0,      1,32'h18,1,32'h08,3,1);
    add(0,1,0,0,      1,32'h1C,1,32'h0C,3,1);
    add(0,1,0,0,      1,32'h20,1,32'h10,3,1);
    // Flush to 0x100 with count=3 and a fetch in flight.
    add(0,1,1,32'h100,0,32'h24,0,32'h00,3,1);
    add(0,1,0,0,      1,32'h100,0,32'h00,0,1);
    add(0,1,0,0,      1,32'h104,0,32'h00,0,1);
    add(0,1,0,0,      1,32'h108,1,32'h100,1,1);
    add(0,1,0,0,      1,32'h10C,1,32'h104,1,1);
    // Reset and flush together: reset wins, fetch restarts at 0.
    add(1,1,1,32'h200,0,32'h00,0,32'h00,0,0);
    add(0,1,0,0,      1,32'h00,0,32'h00,0,1);
    add(0,1,0,0,      1,32'h04,0,32'h00,0,1);
    add(0,1,0,0,      1,32'h08,1,32'h00,1,1);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst4            = tv[i].rst;
      if4.out_ready_i = tv[i].ready;
      if4.flush_i     = tv[i].flush;
      if4.flush_pc_i  = tv[i].fpc;
      #1;
      check("ce", 32'(if4.rom_ce_o), 32'(tv[i].ce), i);
      if (tv[i].chk) begin
        check("addr",  if4.rom_addr_o,       tv[i].addr, i);
        check("valid", 32'(if4.out_valid_o), 32'(tv[i].vld), i);
        check("count", 32'(if4.count_o),     tv[i].cnt, i);
        if (tv[i].vld) begin
          check("pc",   if4.out_pc_o,   tv[i].pc, i);
          check("inst", if4.out_inst_o, tv[i].pc, i);
        end
      end
    end
    @(negedge clk);
    if4.flush_i = 1'b0;
`endif

    // DEPTH=2 with ready toggling: every consumed PC is the next one in order.
    exp_next = 32'h0;
    pops     = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rst2            = 1'b0;
      if2.out_ready_i = (k % 2 == 0);
      #1;
      n_tests++;
      if (if2.count_o > 2) begin
        n_fail++;
        $display("FAIL d2_count cycle %0d: got %0d expected at most 2", k, if2.count_o);
      end
      if (if2.out_valid_o && if2.out_ready_i) begin
        check("d2_pc",   if2.out_pc_o,   exp_next, k);
        check("d2_inst", if2.out_inst_o, exp_next, k);
        exp_next = exp_next + 32'd4;
        pops++;
      end
    end
    n_tests++;
    if (pops < 8) begin
      n_fail++;
      $display("FAIL d2_pops: got %0d expected at least 8", pops);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
